regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Multi-ported successor of the CPU register file: NRD read ports, NWR write ports, registered
//  reads with optional write-to-read bypass, hard-wired zero register, and per-register busy
//  scoreboard (set at issue, cleared at writeback). Sits between decode/issue and writeback.
// PARAMETERS
//  WIDTH    32  data bits per register
//  DEPTH    32  number of registers; ADDR = $clog2(DEPTH) address bits
//  NRD       2  read ports
//  NWR       2  write ports
//  ZERO_REG  1  1: register 0 reads 0, ignores writes, never busy
//  BYPASS    1  1: a read sees a write to the same address at the same edge
// PORTS
//  clk          in   1            clock, all state on posedge
//  reset        in   1            synchronous, active-low (0 = reset)
//  rd_en        in   NRD          per-port read enable
//  rd_addr      in   NRD*ADDR     port k at [k*ADDR +: ADDR]
//  rd_data      out  NRD*WIDTH    port k at [k*WIDTH +: WIDTH], registered
//  rd_busy      out  NRD          busy bit of register read by port k, registered with rd_data
//  wr_en        in   NWR          per-port write enable
//  wr_addr      in   NWR*ADDR     port j at [j*ADDR +: ADDR]
//  wr_data      in   NWR*WIDTH    port j at [j*WIDTH +: WIDTH]
//  iss_en       in   1            mark iss_addr busy (pending producer)
//  iss_addr     in   ADDR         register to mark busy
//  busy_vec     out  DEPTH        current scoreboard, bit i = register i busy
//  wr_conflict  out  1            registered: >=2 enabled write ports hit same valid address
// BEHAVIOUR
//  - Reset (reset==0 at posedge) dominates: all registers, busy_vec, rd_data, rd_busy,
//    wr_conflict <= 0; concurrent writes, issues and reads are discarded.
//  - Write: at posedge, enabled port j writes mem[wr_addr_j] <= wr_data_j. Several ports to
//    same address: highest port index wins; wr_conflict <= 1 for that cycle only, else 0.
//  - Ignored writes: address 0 when ZERO_REG=1; address >= DEPTH (non power-of-2 DEPTH).
//    Ignored writes never count toward wr_conflict.
//  - Read latency 1: rd_en[k]=1 at edge N -> rd_data_k/rd_busy[k] valid after edge N.
//    rd_en[k]=0: rd_data_k and rd_busy[k] hold previous value.
//  - Read value: 0 if address 0 with ZERO_REG=1 or address >= DEPTH; else if BYPASS=1 and an
//    effective write targets same address at same edge, winning write data; else stored value.
//    BYPASS=0: stored (pre-write) value.
//  - Scoreboard: effective write to r clears busy[r]; iss_en sets busy[iss_addr]. Same register
//    issued and written in one cycle: busy stays/becomes 1 (issue wins, new producer).
//    iss_addr 0 (ZERO_REG=1) or >= DEPTH: no effect.
//  - rd_busy[k] is the post-edge busy value (same bypass rule as data, applied regardless of BYPASS).
//  - busy_vec is direct register output, updated at same edge as mem.
//  - No combinational path from inputs to any output.
// TESTING
//  1 Reset: preload r5=0xDEAD, issue r7, reset=0 one cycle -> all reads 0, busy_vec=0, wr_conflict=0.
//  2 Basic: write r3=0x1234 port0; next cycle read r3 port1 -> rd_data_1=0x1234 one cycle later.
//  3 Bypass: r4=0xAAAA; same edge write r4=0x5555 and read r4 -> BYPASS=1: 0x5555; BYPASS=0: 0xAAAA.
//  4 Conflict: port0 r9=0x11, port1 r9=0x22 same cycle -> r9=0x22, wr_conflict=1 for one cycle;
//    repeat with both to r0 -> r0 reads 0, wr_conflict=0.
//  5 Scoreboard: issue r6 -> busy_vec[6]=1; write r6 with iss_en r6 same cycle -> still 1;
//    write r6 alone -> 0; issue r0 -> busy_vec[0]=0.
//  6 Hold/range: DEPTH=24, read addr 30 -> 0; drop rd_en -> rd_data unchanged while mem changes.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-ported register file with registered reads, optional write-to-read bypass,
// hard-wired zero register and a per-register busy scoreboard (issue sets, writeback clears).
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int ADDR    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*ADDR-1:0]   rd_addr,
    output logic [NRD*WIDTH-1:0]  rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR-1:0]   wr_addr,
    input  logic [NWR*WIDTH-1:0]  wr_data,
    input  logic                  iss_en,
    input  logic [ADDR-1:0]       iss_addr,
    output logic [DEPTH-1:0]      busy_vec,
    output logic                  wr_conflict
);

    // Enables are single-cycle qualifiers with no backpressure: every enabled
    // read, write or issue is accepted and completes at the next rising edge.

    function automatic logic addr_ok(input logic [ADDR-1:0] a);
        return (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [NWR-1:0]       wr_ok;
    logic                 conflict_nxt;
    logic [DEPTH-1:0]     busy_nxt;
    logic [NRD*WIDTH-1:0] rd_data_nxt;
    logic [NRD-1:0]       rd_busy_nxt;
    logic [ADDR-1:0]      ra;
    logic                 hit;
    logic [WIDTH-1:0]     wdat;

    always_comb begin
        wr_ok        = '0;
        conflict_nxt = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            wr_ok[j] = wr_en[j] && addr_ok(wr_addr[j*ADDR +: ADDR]);
        end
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                if (wr_ok[i] && wr_ok[j] &&
                    (wr_addr[i*ADDR +: ADDR] == wr_addr[j*ADDR +: ADDR])) begin
                    conflict_nxt = 1'b1;
                end
            end
        end
    end

    // Issue is applied after writeback so a new producer keeps the register busy.
    always_comb begin
        busy_nxt = busy_vec;
        for (int j = 0; j < NWR; j++) begin
            if (wr_ok[j]) begin
                busy_nxt[wr_addr[j*ADDR +: ADDR]] = 1'b0;
            end
        end
        if (iss_en && addr_ok(iss_addr)) begin
            busy_nxt[iss_addr] = 1'b1;
        end
    end

    always_comb begin
        rd_data_nxt = '0;
        rd_busy_nxt = '0;
        ra          = '0;
        hit         = 1'b0;
        wdat        = '0;
        for (int k = 0; k < NRD; k++) begin
            ra   = rd_addr[k*ADDR +: ADDR];
            hit  = 1'b0;
            wdat = '0;
            // Ascending scan: the highest-indexed matching port is the one that lands.
            for (int j = 0; j < NWR; j++) begin
                if (wr_ok[j] && (wr_addr[j*ADDR +: ADDR] == ra)) begin
                    hit  = 1'b1;
                    wdat = wr_data[j*WIDTH +: WIDTH];
                end
            end
            if (addr_ok(ra)) begin
                rd_data_nxt[k*WIDTH +: WIDTH] = ((BYPASS != 0) && hit) ? wdat : mem[ra];
                rd_busy_nxt[k]                = busy_nxt[ra];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy_vec    <= '0;
            rd_data     <= '0;
            rd_busy     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_ok[j]) begin
                    mem[wr_addr[j*ADDR +: ADDR]] <= wr_data[j*WIDTH +: WIDTH];
                end
            end
            busy_vec    <= busy_nxt;
            wr_conflict <= conflict_nxt;
            for (int k = 0; k < NRD; k++) begin
                if (rd_en[k]) begin
                    rd_data[k*WIDTH +: WIDTH] <= rd_data_nxt[k*WIDTH +: WIDTH];
                    rd_busy[k]                <= rd_busy_nxt[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (DEPTH=32, bypass) and a DEPTH=24 no-bypass
// instance share stimulus; a directed vector table plus random cycles feed a reference model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [31:0] busy_vec_a;
    logic [23:0] busy_vec_b;
    logic        conf_a, conf_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_mp dut_a (
        .clk(clk), .reset(reset),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_vec(busy_vec_a), .wr_conflict(conf_a)
    );

    regfile_mp #(.DEPTH(24), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_vec(busy_vec_b), .wr_conflict(conf_b)
    );

    // Field order: reset, write enables, port0 addr/data, port1 addr/data, issue,
    // read enables, read addrs, then expected outputs of dut_a after the edge.
    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ia;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [31:0] ebusy;
        logic        econf;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    // Observation word: {conflict, busy_vec, rd_busy, rd_data port1, rd_data port0}
    logic [98:0] exp_q_a [$];
    logic [98:0] exp_q_b [$];

    logic [31:0] mm   [2][32];
    logic [31:0] mb   [2];
    logic [31:0] mrd  [2][2];
    logic [1:0]  mrb  [2];
    logic        mconf[2];

    function automatic vec_t mk(input int rst, we, wa0, wd0, wa1, wd1, ie, ia,
                                re, ra0, ra1, ed0, ed1, eb, ec);
        vec_t v;
        v.rst = 1'(rst);  v.we = 2'(we);
        v.wa0 = 5'(wa0);  v.wd0 = 32'(wd0);
        v.wa1 = 5'(wa1);  v.wd1 = 32'(wd1);
        v.ie = 1'(ie);    v.ia = 5'(ia);
        v.re = 2'(re);    v.ra0 = 5'(ra0);  v.ra1 = 5'(ra1);
        v.ed0 = 32'(ed0); v.ed1 = 32'(ed1);
        v.ebusy = 32'(eb); v.econf = 1'(ec);
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input int inst, input int depth, input bit byp);
        logic [31:0] nm [32];
        logic [31:0] nb;
        logic [31:0] wmask;
        logic        conf;
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic [4:0]  ra [2];
        wa[0] = wr_addr[4:0];  wa[1] = wr_addr[9:5];
        wd[0] = wr_data[31:0]; wd[1] = wr_data[63:32];
        ra[0] = rd_addr[4:0];  ra[1] = rd_addr[9:5];
        if (!reset) begin
            for (int i = 0; i < 32; i++) mm[inst][i] = '0;
            mb[inst] = '0;
            mrd[inst][0] = '0;
            mrd[inst][1] = '0;
            mrb[inst] = '0;
            mconf[inst] = 1'b0;
        end else begin
            nm = mm[inst];
            wmask = '0;
            conf = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && wa[j] != 0 && int'(wa[j]) < depth) begin
                    if (wmask[wa[j]]) conf = 1'b1;
                    wmask[wa[j]] = 1'b1;
                    nm[wa[j]] = wd[j];
                end
            end
            nb = mb[inst] & ~wmask;
            if (iss_en && iss_addr != 0 && int'(iss_addr) < depth) nb[iss_addr] = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (rd_en[k]) begin
                    if (ra[k] == 0 || int'(ra[k]) >= depth) begin
                        mrd[inst][k] = '0;
                        mrb[inst][k] = 1'b0;
                    end else begin
                        mrd[inst][k] = (byp && wmask[ra[k]]) ? nm[ra[k]] : mm[inst][ra[k]];
                        mrb[inst][k] = nb[ra[k]];
                    end
                end
            end
            mm[inst] = nm;
            mb[inst] = nb;
            mconf[inst] = conf;
        end
        if (inst == 0) exp_q_a.push_back({mconf[0], mb[0], mrb[0], mrd[0][1], mrd[0][0]});
        else           exp_q_b.push_back({mconf[1], mb[1], mrb[1], mrd[1][1], mrd[1][0]});
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        reset    = v.rst;
        wr_en    = v.we;
        wr_addr  = {v.wa1, v.wa0};
        wr_data  = {v.wd1, v.wd0};
        iss_en   = v.ie;
        iss_addr = v.ia;
        rd_en    = v.re;
        rd_addr  = {v.ra1, v.ra0};
    endtask

    task automatic step_and_score();
        logic [98:0] ea, eb;
        model_step(0, 32, 1'b1);
        model_step(1, 24, 1'b0);
        @(posedge clk);
        #1;
        ea = exp_q_a.pop_front();
        eb = exp_q_b.pop_front();
        chk("sb_a", 128'({conf_a, busy_vec_a, rd_busy_a, rd_data_a}), 128'(ea));
        chk("sb_b", 128'({conf_b, 8'h00, busy_vec_b, rd_busy_b, rd_data_b}), 128'(eb));
    endtask

    initial begin
        reset = 1'b0; rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0;
        wr_data = '0; iss_en = 1'b0; iss_addr = '0;

        vecs[0]  = mk(0, 0, 0, 0,       0, 0,       0, 0, 0, 0, 0,  0,       0,       0,     0);
        vecs[1]  = mk(1, 1, 5, 'hDEAD,  0, 0,       1, 7, 0, 0, 0,  0,       0,       'h80,  0);
        vecs[2]  = mk(1, 0, 0, 0,       0, 0,       0, 0, 3, 5, 7,  'hDEAD,  0,       'h80,  0);
        vecs[3]  = mk(0, 1, 5, 'h1111,  0, 0,       1, 8, 3, 5, 5,  0,       0,       0,     0);
        vecs[4]  = mk(1, 0, 0, 0,       0, 0,       0, 0, 3, 5, 7,  0,       0,       0,     0);
        vecs[5]  = mk(1, 1, 3, 'h1234,  0, 0,       0, 0, 0, 0, 0,  0,       0,       0,     0);
        vecs[6]  = mk(1, 0, 0, 0,       0, 0,       0, 0, 2, 0, 3,  0,       'h1234,  0,     0);
        vecs[7]  = mk(1, 1, 4, 'hAAAA,  0, 0,       0, 0, 0, 0, 0,  0,       'h1234,  0,     0);
        vecs[8]  = mk(1, 2, 0, 0,       4, 'h5555,  0, 0, 1, 4, 0,  'h5555,  'h1234,  0,     0);
        vecs[9]  = mk(1, 3, 9, 'h11,    9, 'h22,    0, 0, 1, 9, 0,  'h22,    'h1234,  0,     1);
        vecs[10] = mk(1, 0, 0, 0,       0, 0,       0, 0, 1, 9, 0,  'h22,    'h1234,  0,     0);
        vecs[11] = mk(1, 3, 0, 'h33,    0, 'h44,    0, 0, 3, 0, 0,  0,       0,       0,     0);
        vecs[12] = mk(1, 0, 0, 0,       0, 0,       1, 6, 0, 0, 0,  0,       0,       'h40,  0);
        vecs[13] = mk(1, 1, 6, 'h66,    0, 0,       1, 6, 0, 0, 0,  0,       0,       'h40,  0);
        vecs[14] = mk(1, 1, 6, 'h67,    0, 0,       0, 0, 0, 0, 0,  0,       0,       0,     0);
        vecs[15] = mk(1, 0, 0, 0,       0, 0,       1, 0, 3, 6, 9,  'h67,    'h22,    0,     0);
        vecs[16] = mk(1, 0, 0, 0,       0, 0,       0, 0, 3, 30, 4, 0,       'h5555,  0,     0);
        vecs[17] = mk(1, 1, 4, 'hBEEF,  0, 0,       0, 0, 0, 0, 0,  0,       'h5555,  0,     0);
        vecs[18] = mk(1, 0, 0, 0,       0, 0,       0, 0, 0, 0, 0,  0,       'h5555,  0,     0);
        vecs[19] = mk(1, 0, 0, 0,       0, 0,       0, 0, 2, 0, 4,  0,       'hBEEF,  0,     0);
        vecs[20] = mk(1, 3, 26, 'hCAFE, 26, 'hF00D, 0, 0, 1, 26, 0, 'hF00D,  'hBEEF,  0,     1);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            step_and_score();
            chk($sformatf("v%0d_rd0", i),  128'(rd_data_a[31:0]),  128'(vecs[i].ed0));
            chk($sformatf("v%0d_rd1", i),  128'(rd_data_a[63:32]), 128'(vecs[i].ed1));
            chk($sformatf("v%0d_busy", i), 128'(busy_vec_a),       128'(vecs[i].ebusy));
            chk($sformatf("v%0d_conf", i), 128'(conf_a),           128'(vecs[i].econf));
            if (i == 2)  chk("rd_busy_r7_a", 128'(rd_busy_a[1]), 128'(1));
            if (i == 8)  chk("nobypass_b",   128'(rd_data_b[31:0]), 128'(32'hAAAA));
            if (i == 16) chk("oor30_b",      128'(rd_data_b[31:0]), 128'(0));
            if (i == 20) begin
                chk("oor_wr_rd_b",   128'(rd_data_b[31:0]), 128'(0));
                chk("oor_wr_conf_b", 128'(conf_b),          128'(0));
            end
        end

        for (int n = 0; n < 300; n++) begin
            vec_t v;
            v = mk(($urandom_range(0, 63) != 0) ? 1 : 0, $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                   $urandom,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                   $urandom,
                   $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                   0, 0, 0, 0);
            drive(v);
            step_and_score();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
